// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and MOD legality check for param_updown_counter
package counter_pkg;
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
   function automatic bit mod_legal(input int unsigned width, input longint unsigned modulus);
      return width >= 2 && width <= 32 && modulus >= 2 && modulus <= (64'd1 << width);
   endfunction
endpackage

// File: rtl/updown_next.sv
// updown_next: combinational modulo-MOD next count and end-of-range (wrap) flag
//   y      in  current count
//   updown in  direction (DIR_UP / DIR_DOWN)
//   nxt    out wrapped next count
//   wrap   out y sits at the end of range for this direction
module updown_next
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH = 3,
   parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
   input  logic [WIDTH-1:0] y,
   input  logic             updown,
   output logic [WIDTH-1:0] nxt,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
   logic up;
   assign up   = updown == DIR_UP;
   assign wrap = up ? (y == MAXV) : (y == '0);
   assign nxt  = wrap ? (up ? '0 : MAXV) : (up ? y + 1'b1 : y - 1'b1);
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: modulo-MOD up/down counter with clamped load, terminal count and wrap pulse
//   clk    in  clock, rising edge
//   rst    in  asynchronous active-low reset
//   en     in  count enable
//   updown in  direction, 1 = up
//   load   in  synchronous load strobe (beats en)
//   din    in  load value, clamped to MOD-1
//   y      out registered count
//   tc     out combinational terminal count
//   wrap   out registered one-cycle wrap pulse
// Build option: COUNTER_SATURATE_EN makes the counter stop at the end of range (wrap stays 0).
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned     WIDTH = 3,
   parameter longint unsigned MOD   = 64'd1 << WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             updown,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] y,
   output logic             tc,
   output logic             wrap
);
   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 1);
   if (!mod_legal(WIDTH, MOD)) begin : g_bad_mod
      $error("param_updown_counter: illegal WIDTH/MOD combination");
   end
   logic [WIDTH-1:0] y_q, y_d, nxt, clamp;
   logic             wrap_q, wrap_d, nxt_wrap;
   updown_next #(.WIDTH(WIDTH), .MOD(MOD)) u_next (
      .y(y_q),
      .updown(updown),
      .nxt(nxt),
      .wrap(nxt_wrap)
   );
   assign clamp = (64'(din) < MOD) ? din : MAXV;
`ifdef COUNTER_SATURATE_EN
   assign y_d    = load ? clamp : (en && !nxt_wrap) ? nxt : y_q;
   assign wrap_d = 1'b0;
`else
   assign y_d    = load ? clamp : en ? nxt : y_q;
   assign wrap_d = !load && en && nxt_wrap;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         y_q    <= y_d;
         wrap_q <= wrap_d;
      end
   end
   assign tc   = en && !load && ((updown == DIR_UP && y_q == MAXV) || (updown == DIR_DOWN && y_q == '0));
   assign y    = y_q;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: vector table, reset sequences and random stimulus against a modular-arithmetic model
module tb_param_updown_counter;
   localparam int W = 3;
   localparam int M = 6;
   logic clk = 1'b0, rst = 1'b0, en = 1'b0, updown = 1'b0, load = 1'b0;
   logic [W-1:0] din = '0;
   logic [W-1:0] y;
   logic tc, wrap;
   int checks = 0, failures = 0;
   int m_y = 0;
   bit m_w = 1'b0;
   bit use_model = 1'b0;
   logic tc_s;
   typedef struct {
      logic e, u, l;
      logic [W-1:0] d;
      int y;
      logic w, tc;
   } vec_t;
   vec_t tbl[$];

   param_updown_counter #(.WIDTH(W), .MOD(M)) dut (
      .clk(clk), .rst(rst), .en(en), .updown(updown), .load(load),
      .din(din), .y(y), .tc(tc), .wrap(wrap)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] d);
      int nx;
      bit wr;
      @(negedge clk);
      en = e; updown = u; load = l; din = d;
      #1;
      tc_s = tc;
      if (use_model) check("rand_tc", tc, e && !l && ((u && m_y == M-1) || (!u && m_y == 0)));
      @(posedge clk);
      if (l) begin
         m_y = (int'(d) < M) ? int'(d) : M-1;
         m_w = 1'b0;
      end else if (e) begin
         wr = u ? (m_y == M-1) : (m_y == 0);
         nx = u ? (m_y + 1) % M : (m_y + M - 1) % M;
`ifdef COUNTER_SATURATE_EN
         if (wr) nx = m_y;
         wr = 1'b0;
`endif
         m_y = nx;
         m_w = wr;
      end else m_w = 1'b0;
      #1;
      if (use_model) begin
         check("rand_y", y, m_y);
         check("rand_wrap", wrap, m_w);
      end
   endtask

   initial begin
`ifdef COUNTER_SATURATE_EN
      tbl.push_back('{0,0,1,4, 4,0,0});
      tbl.push_back('{1,1,0,0, 5,0,0});
      tbl.push_back('{1,1,0,0, 5,0,1});
      tbl.push_back('{1,1,0,0, 5,0,1});
      tbl.push_back('{0,0,1,0, 0,0,0});
      tbl.push_back('{1,0,0,0, 0,0,1});
      tbl.push_back('{1,0,1,7, 5,0,0});
      tbl.push_back('{1,1,0,0, 5,0,1});
      tbl.push_back('{0,1,0,0, 5,0,0});
`else
      tbl.push_back('{1,1,0,0, 1,0,0});
      tbl.push_back('{1,1,0,0, 2,0,0});
      tbl.push_back('{1,1,0,0, 3,0,0});
      tbl.push_back('{1,1,0,0, 4,0,0});
      tbl.push_back('{1,1,0,0, 5,0,0});
      tbl.push_back('{1,1,0,0, 0,1,1});
      tbl.push_back('{1,1,0,0, 1,0,0});
      tbl.push_back('{0,0,1,1, 1,0,0});
      tbl.push_back('{1,0,0,0, 0,0,0});
      tbl.push_back('{1,0,0,0, 5,1,1});
      tbl.push_back('{1,0,0,0, 4,0,0});
      tbl.push_back('{1,1,1,7, 5,0,0});
      tbl.push_back('{1,1,1,2, 2,0,0});
      tbl.push_back('{0,0,1,5, 5,0,0});
      tbl.push_back('{1,1,0,0, 0,1,1});
      tbl.push_back('{1,0,1,6, 5,0,0});
      tbl.push_back('{0,0,1,3, 3,0,0});
      tbl.push_back('{0,1,0,0, 3,0,0});
      tbl.push_back('{0,0,0,0, 3,0,0});
      tbl.push_back('{0,1,0,0, 3,0,0});
      tbl.push_back('{0,0,0,0, 3,0,0});
      tbl.push_back('{1,1,0,0, 4,0,0});
      tbl.push_back('{1,0,0,0, 3,0,0});
      tbl.push_back('{1,1,0,0, 4,0,0});
`endif
      #3;
      check("reset_y", y, 0);
      check("reset_wrap", wrap, 0);
      @(negedge clk);
      rst = 1'b1;
      foreach (tbl[i]) begin
         step(tbl[i].e, tbl[i].u, tbl[i].l, tbl[i].d);
         check($sformatf("vec%0d_y", i), y, tbl[i].y);
         check($sformatf("vec%0d_wrap", i), wrap, tbl[i].w);
         check($sformatf("vec%0d_tc", i), tc_s, tbl[i].tc);
      end
      step(0, 0, 1, 4);
      @(negedge clk);
      #2;
      rst = 1'b0; en = 1'b1; updown = 1'b1; load = 1'b1; din = 3'd3;
      #1;
      check("async_rst_y", y, 0);
      check("async_rst_wrap", wrap, 0);
      check("rst_tc_load", tc, 0);
      load = 1'b0; updown = 1'b0;
      #1;
      check("rst_tc_down", tc, 1);
      @(posedge clk);
      #1;
      check("rst_hold_y", y, 0);
      @(negedge clk);
      rst = 1'b1; en = 1'b1; updown = 1'b1; load = 1'b0;
      @(posedge clk);
      #1;
      check("rst_release_y", y, 1);
      check("rst_release_wrap", wrap, 0);
      m_y = 1; m_w = 1'b0;
      step(0, 0, 1, 0);
      step(1, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_wrap_pulse", wrap, 0);
      check("async_rst_wrap_y", y, 0);
      @(negedge clk);
      en = 1'b0; load = 1'b0; rst = 1'b1;
      m_y = 0; m_w = 1'b0;
      use_model = 1'b1;
      repeat (400) step(1'($urandom_range(0, 3) != 0), 1'($urandom % 2), 1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
